// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the cipher core.
// The watchdog option is enabled with AES_CORE_KEY_TIMEOUT_EN.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_KEY = 2'd1,
        DONE     = 2'd2
    } state_e;

    localparam int NUM_KEYS = 15;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_KEYS - 1);
    localparam int KEY_TIMEOUT = 64;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte r+4c holds row r, column c of the FIPS-197 state.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
// Shared between the cipher rounds and the key generator's SubWord.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits at the MSB, so its top bit index is 2047 - 8*in.
    logic [10:0] idx;

    assign idx      = ~{in_byte, 3'b000};
    assign out_byte = SBOX[idx -: 8];

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-256 encryption core, one round per round-key strobe.
// Define AES_CORE_KEY_TIMEOUT_EN to enable the key-strobe watchdog.
module aes_cipher_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic         key_advance,
    input  logic [127:0] key_in,
    input  logic         key_in_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         busy,
    output logic         key_err
);

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         key_advance_q, key_advance_d;

    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] round_out;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (st_q[127-8*i -: 8]),
            .out_byte (sb[127-8*i -: 8])
        );
    end

    assign sr = shift_rows(sb);
    assign mc = mix_columns(sr);

    always_comb begin
        round_out = mc ^ key_in;
        if (rnd_q == 4'd0) begin
            round_out = st_q ^ key_in;
        end else if (rnd_q == LAST_ROUND) begin
            round_out = sr ^ key_in;
        end
    end

`ifdef AES_CORE_KEY_TIMEOUT_EN
    localparam int WDOG_W = $clog2(KEY_TIMEOUT);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              key_err_q, key_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        st_d          = st_q;
        rnd_d         = rnd_q;
        key_advance_d = 1'b0;
`ifdef AES_CORE_KEY_TIMEOUT_EN
        wdog_d        = wdog_q;
        key_err_d     = key_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d          = in_block;
                    rnd_d         = 4'd0;
                    key_advance_d = 1'b1;
                    state_d       = WAIT_KEY;
`ifdef AES_CORE_KEY_TIMEOUT_EN
                    wdog_d        = '0;
                    key_err_d     = 1'b0;
`endif
                end
            end
            WAIT_KEY: begin
                if (key_in_valid) begin
                    st_d  = round_out;
                    rnd_d = rnd_q + 4'd1;
`ifdef AES_CORE_KEY_TIMEOUT_EN
                    wdog_d = '0;
`endif
                    if (rnd_q == LAST_ROUND) begin
                        state_d = DONE;
                    end
`ifdef AES_CORE_KEY_TIMEOUT_EN
                end else if (wdog_q == WDOG_W'(KEY_TIMEOUT - 1)) begin
                    // Generator stalled: drop the partial block.
                    key_err_d = 1'b1;
                    st_d      = '0;
                    rnd_d     = 4'd0;
                    wdog_d    = '0;
                    state_d   = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            st_q          <= '0;
            rnd_q         <= 4'd0;
            key_advance_q <= 1'b0;
`ifdef AES_CORE_KEY_TIMEOUT_EN
            wdog_q        <= '0;
            key_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            st_q          <= st_d;
            rnd_q         <= rnd_d;
            key_advance_q <= key_advance_d;
`ifdef AES_CORE_KEY_TIMEOUT_EN
            wdog_q        <= wdog_d;
            key_err_q     <= key_err_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == WAIT_KEY);
    assign out_block   = st_q;
    assign key_advance = key_advance_q;

`ifdef AES_CORE_KEY_TIMEOUT_EN
    assign key_err = key_err_q;
`else
    assign key_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed bench for aes_cipher_core using the FIPS-197 C.3 vector.
// Round keys come from an AES-256 key expansion computed here.
module tb_aes_cipher_core;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] ST1 = 128'h00102030405060708090a0b0c0d0e0f0;

    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_block = '0;
    logic         key_advance;
    logic [127:0] key_in = '0;
    logic         key_in_valid = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_block;
    logic         busy;
    logic         key_err;

    int total = 0;
    int bad = 0;
    int kadv_cnt = 0;

    logic [127:0] rk [15];

    aes_cipher_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_block     (in_block),
        .key_advance  (key_advance),
        .key_in       (key_in),
        .key_in_valid (key_in_valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_block    (out_block),
        .busy         (busy),
        .key_err      (key_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_advance) kadv_cnt++;
    end

    function automatic logic [7:0] tsb(input logic [7:0] b);
        logic [10:0] i;
        i = ~{b, 3'b000};
        return SBOX_T[i -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tsb(w[31:24]), tsb(w[23:16]), tsb(w[15:8]), tsb(w[7:0])};
    endfunction

    task automatic expand_key;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) begin
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        end
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0};
            end else if (i % 8 == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) begin
            rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] pt);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        in_valid = 1'b1;
        in_block = pt;
        step();
        in_valid = 1'b0;
        in_block = '0;
    endtask

    task automatic feed(input int first, input int last,
                        input int gap, input bit rnd_gap);
        for (int k = first; k <= last; k++) begin
            int g;
            g = rnd_gap ? int'($urandom_range(0, 9)) : gap;
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            key_in       = rk[k];
            key_in_valid = 1'b1;
            step();
            key_in_valid = 1'b0;
            key_in       = '0;
        end
    endtask

    task automatic test_reset;
        total++;
        if ({in_ready, out_valid, key_advance, busy, key_err} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=10000",
                     {in_ready, out_valid, key_advance, busy, key_err});
        end
        total++;
        if (out_block !== 128'h0) begin
            bad++;
            $display("FAIL reset_block got=%h want=0", out_block);
        end
    endtask

    task automatic test_fips;
        kadv_cnt = 0;
        send(PT);
        total++;
        if (key_advance !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL accept got kadv=%b busy=%b rdy=%b want 1 1 0",
                     key_advance, busy, in_ready);
        end
        feed(0, 0, 0, 1'b0);
        total++;
        if (out_block !== ST1 || key_advance !== 1'b0) begin
            bad++;
            $display("FAIL first_round got=%h kadv=%b want=%h kadv=0",
                     out_block, key_advance, ST1);
        end
        feed(1, 14, 0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || out_block !== CT) begin
            bad++;
            $display("FAIL fips_ct got v=%b %h want v=1 %h",
                     out_valid, out_block, CT);
        end
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || kadv_cnt !== 1) begin
            bad++;
            $display("FAIL fips_flags got rdy=%b busy=%b kadv=%0d want 0 0 1",
                     in_ready, busy, kadv_cnt);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL fips_release got v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_spacing;
        for (int m = 0; m < 2; m++) begin
            kadv_cnt = 0;
            send(PT);
            feed(0, 6, 3, m == 1);
            // A competing plaintext while busy must be ignored.
            in_valid = 1'b1;
            in_block = ~PT;
            feed(7, 14, 3, m == 1);
            in_valid = 1'b0;
            in_block = '0;
            total++;
            if (out_valid !== 1'b1 || out_block !== CT || kadv_cnt !== 1) begin
                bad++;
                $display("FAIL spacing%0d got v=%b %h kadv=%0d want v=1 %h kadv=1",
                         m, out_valid, out_block, kadv_cnt, CT);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_hold_done;
        int errs;
        errs = 0;
        send(PT);
        feed(0, 14, 0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            key_in_valid = 1'b1;
            key_in       = {4{$urandom}};
            in_valid     = 1'b1;
            in_block     = ~PT;
            step();
            total++;
            if (out_valid !== 1'b1 || out_block !== CT || in_ready !== 1'b0) begin
                bad++;
                errs++;
                if (errs < 4) begin
                    $display("FAIL hold_c%0d got v=%b rdy=%b %h want v=1 rdy=0 %h",
                             c, out_valid, in_ready, out_block, CT);
                end
            end
        end
        key_in_valid = 1'b0;
        key_in       = '0;
        in_valid     = 1'b0;
        in_block     = '0;
        out_ready    = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid;
        send(PT);
        feed(0, 6, 1, 1'b0);
        rst_n = 1'b0;
        #2;
        total++;
        if ({in_ready, out_valid, key_advance, busy, key_err} !== 5'b10000 ||
            out_block !== 128'h0) begin
            bad++;
            $display("FAIL mid_reset got flags=%b blk=%h want 10000 0",
                     {in_ready, out_valid, key_advance, busy, key_err}, out_block);
        end
        step();
        rst_n = 1'b1;
        step();
        send(PT);
        feed(0, 14, 0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || out_block !== CT) begin
            bad++;
            $display("FAIL post_reset_ct got v=%b %h want v=1 %h",
                     out_valid, out_block, CT);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_key_stall;
        bit seen_ov;
        seen_ov = 1'b0;
        send(PT);
        feed(0, 4, 0, 1'b0);
`ifdef AES_CORE_KEY_TIMEOUT_EN
        for (int c = 0; c < 100 && !key_err; c++) begin
            step();
            if (out_valid) seen_ov = 1'b1;
        end
        total++;
        if (key_err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 ||
            seen_ov || out_block !== 128'h0) begin
            bad++;
            $display("FAIL timeout got err=%b rdy=%b busy=%b ov=%b blk=%h want 1 1 0 0 0",
                     key_err, in_ready, busy, seen_ov, out_block);
        end
        send(PT);
        total++;
        if (key_err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got=%b want=0", key_err);
        end
        feed(0, 14, 0, 1'b0);
`else
        for (int c = 0; c < 80; c++) begin
            step();
            if (out_valid) seen_ov = 1'b1;
        end
        total++;
        if (key_err !== 1'b0 || busy !== 1'b1 || seen_ov) begin
            bad++;
            $display("FAIL stall got err=%b busy=%b ov=%b want 0 1 0",
                     key_err, busy, seen_ov);
        end
        feed(5, 14, 0, 1'b0);
`endif
        total++;
        if (out_valid !== 1'b1 || out_block !== CT) begin
            bad++;
            $display("FAIL stall_ct got v=%b %h want v=1 %h",
                     out_valid, out_block, CT);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        expand_key();
        #3;
        test_reset();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_fips();
        test_spacing();
        test_hold_done();
        test_reset_mid();
        test_key_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
